// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequential N-input neuron.
// A bias is loaded on start, one signed W*X product is accumulated per
// accepted pair into an accumulator wide enough to never overflow, and a
// selectable saturating activation produces one registered WIDTH-bit result.
module neuron_mac_seq #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] bias,
    input  logic [1:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] W,
    input  logic signed [WIDTH-1:0] X,
    output logic                    busy,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] Out
);

    // Accumulator width covers N_IN full products plus the bias without overflow.
    localparam int ACC_WIDTH = 2*WIDTH + $clog2(N_IN) + 1;
    localparam int CNT_W     = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);

    // Activation limits, in accumulator and output widths.
    localparam logic signed [ACC_WIDTH-1:0] ZERO_A = {ACC_WIDTH{1'b0}};
    localparam logic signed [ACC_WIDTH-1:0] MAX_A  =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_A  =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
    localparam logic signed [WIDTH-1:0] ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [WIDTH-1:0] NEG_ONE_W = {WIDTH{1'b1}};
    localparam logic signed [WIDTH-1:0] MAX_W     = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W     = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_ACT  = 2'd2
    } state_t;

    state_t                      state_r;
    state_t                      state_next_s;
    logic signed [ACC_WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]            cnt_r;
    logic [1:0]                  mode_r;
    logic signed [WIDTH-1:0]     out_r;
    logic                        out_valid_r;
    logic                        in_ready_r;
    logic                        busy_r;
    logic signed [2*WIDTH-1:0]   prod_s;
    logic signed [ACC_WIDTH-1:0] prod_ext_s;
    logic signed [ACC_WIDTH-1:0] bias_ext_s;
    logic                        pair_accept_s;
    logic                        last_pair_s;

    // Saturating activation of the full-width accumulator.
    function automatic logic signed [WIDTH-1:0] activate(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic [1:0]                  m
    );
        logic signed [WIDTH-1:0] res;
        res = ZERO_W;
        case (m)
            2'd0: begin
                if (a > ZERO_A) res = ONE_W;
                else            res = ZERO_W;
            end
            2'd1: begin
                if (a <= ZERO_A)     res = ZERO_W;
                else if (a > MAX_A)  res = MAX_W;
                else                 res = a[WIDTH-1:0];
            end
            2'd2: begin
                if (a > MAX_A)       res = MAX_W;
                else if (a < MIN_A)  res = MIN_W;
                else                 res = a[WIDTH-1:0];
            end
            2'd3: begin
                if (a > ZERO_A)      res = ONE_W;
                else if (a < ZERO_A) res = NEG_ONE_W;
                else                 res = ZERO_W;
            end
            default: res = ZERO_W;
        endcase
        return res;
    endfunction

    assign prod_s        = W * X;
    assign prod_ext_s    = {{(ACC_WIDTH-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
    assign bias_ext_s    = {{(ACC_WIDTH-WIDTH){bias[WIDTH-1]}}, bias};
    assign pair_accept_s = (state_r == S_ACC) && in_valid;
    assign last_pair_s   = (cnt_r == CNT_LAST);

    assign in_ready  = in_ready_r;
    assign busy      = busy_r;
    assign out_valid = out_valid_r;
    assign Out       = out_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= S_IDLE;
        else      state_r <= state_next_s;
    end

    // Next-state logic: IDLE -> ACC on start, ACC -> ACT on last pair, ACT -> IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_next_s = S_ACC;
                else       state_next_s = S_IDLE;
            end
            S_ACC: begin
                if (pair_accept_s && last_pair_s) state_next_s = S_ACT;
                else                              state_next_s = S_ACC;
            end
            S_ACT:   state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath and registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r       <= {ACC_WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            mode_r      <= 2'd0;
            out_r       <= {WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            in_ready_r  <= (state_next_s == S_ACC);
            busy_r      <= (state_next_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        acc_r  <= bias_ext_s;
                        mode_r <= mode;
                        cnt_r  <= {CNT_W{1'b0}};
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        acc_r <= acc_r + prod_ext_s;
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                S_ACT: begin
                    out_r       <= activate(acc_r, mode_r);
                    out_valid_r <= 1'b1;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: expected results are computed by an
// integer model when an evaluation is started, queued, and compared when
// out_valid is seen.
module tb_neuron_mac_seq;

    localparam int N_IN = 4;
    typedef int vec_t [N_IN];

    logic              clk;
    logic              rst_n;
    logic              start;
    logic signed [7:0] bias;
    logic [1:0]        mode;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] W;
    logic signed [7:0] X;
    logic              busy;
    logic              out_valid;
    logic signed [7:0] Out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    logic signed [7:0] exp_q[$];

    neuron_mac_seq #(.WIDTH(8), .N_IN(N_IN)) dut (
        .clk(clk), .rst(rst_n), .start(start), .bias(bias), .mode(mode),
        .in_valid(in_valid), .in_ready(in_ready), .W(W), .X(X),
        .busy(busy), .out_valid(out_valid), .Out(Out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used for latency checks.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int model(input int b, input int m, input vec_t w, input vec_t x);
        int a;
        a = b;
        for (int i = 0; i < N_IN; i++) a = a + w[i] * x[i];
        case (m)
            0: return (a > 0) ? 1 : 0;
            1: return (a <= 0) ? 0 : ((a > 127) ? 127 : a);
            2: return (a > 127) ? 127 : ((a < -128) ? -128 : a);
            default: return (a > 0) ? 1 : ((a < 0) ? -1 : 0);
        endcase
    endfunction

    // Called at a negedge: present start and queue the expected result.
    task automatic start_eval(input int b, input int m, input vec_t w, input vec_t x);
        start = 1'b1;
        bias  = 8'(b);
        mode  = 2'(m);
        exp_q.push_back(8'(model(b, m, w, x)));
        start_cyc = cyc;
    endtask

    // Feed the pairs, scrambling bias/mode after start, with optional gaps and a stray start.
    task automatic feed_pairs(input vec_t w, input vec_t x, input bit gaps, input bit poke);
        for (int i = 0; i < N_IN; i++) begin
            @(negedge clk);
            start = 1'b0;
            bias  = 8'($urandom);
            mode  = 2'($urandom);
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 2));
                for (int j = 0; j < g; j++) begin
                    in_valid = 1'b0;
                    W = 8'($urandom);
                    X = 8'($urandom);
                    @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b1) begin
                        errors++;
                        $display("FAIL gap_in_ready: got %b expected 1", in_ready);
                    end
                end
            end
            if (poke && i == 1) start = 1'b1;
            in_valid = 1'b1;
            W = 8'(w[i]);
            X = 8'(x[i]);
        end
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        W = 8'($urandom);
        X = 8'($urandom);
    endtask

    // Wait (bounded) for out_valid, pop the scoreboard and compare.
    task automatic collect(input string name, input bit chk_lat);
        int n;
        logic signed [7:0] e;
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_ready_outside_acc: got %b expected 0", name, in_ready);
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 30) begin
            errors++;
            $display("FAIL %s_timeout: out_valid never seen, expected a result", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            if (Out !== e) begin
                errors++;
                $display("FAIL %s_out: got %0d expected %0d", name, Out, e);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL %s_busy: got %b expected 0", name, busy);
            end
            if (chk_lat) begin
                checks++;
                if (cyc - start_cyc !== N_IN + 2) begin
                    errors++;
                    $display("FAIL %s_latency: got %0d expected %0d", name, cyc - start_cyc, N_IN + 2);
                end
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || Out !== e) begin
                errors++;
                $display("FAIL %s_pulse_hold: got valid=%b out=%0d expected valid=0 out=%0d",
                         name, out_valid, Out, e);
            end
        end
    endtask

    task automatic run_eval(input string name, input int b, input int m,
                            input vec_t w, input vec_t x, input bit gaps, input bit poke);
        @(negedge clk);
        start_eval(b, m, w, x);
        feed_pairs(w, x, gaps, poke);
        collect(name, !gaps);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        bias = 8'sd0; mode = 2'd0; W = 8'sd0; X = 8'sd0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || Out !== 8'sd0) begin
            errors++;
            $display("FAIL reset: got ready=%b busy=%b valid=%b out=%0d expected all 0",
                     in_ready, busy, out_valid, Out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_step();
        run_eval("step", 0, 0, '{-3, 5, 1, 2}, '{2, -4, 1, 2}, 1'b0, 1'b0);
    endtask

    task automatic test_relu();
        run_eval("relu_sat", 10, 1, '{64, 64, 64, 64}, '{2, 2, 2, 2}, 1'b0, 1'b0);
        run_eval("relu_neg", -128, 1, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0, 1'b0);
    endtask

    task automatic test_linear();
        run_eval("lin_min", -5, 2, '{-128, -128, -128, -128}, '{127, 127, 127, 127}, 1'b0, 1'b0);
        run_eval("lin_mid", 3, 2, '{2, -1, 0, 1}, '{3, 4, 9, 1}, 1'b0, 1'b0);
    endtask

    task automatic test_sign_gaps();
        // Pairs offered while idle must be refused and not disturb the next result.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1; W = 8'sd100; X = 8'sd100;
            checks++;
            if (in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_ready: got ready=%b busy=%b expected 0 0", in_ready, busy);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        run_eval("sign", 0, 3, '{1, 0, 0, 0}, '{-1, 0, 0, 0}, 1'b0, 1'b0);
        run_eval("sign_gaps", 0, 3, '{1, 0, 0, 0}, '{-1, 0, 0, 0}, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        start = 1'b1; bias = 8'sd50; mode = 2'd2;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0; in_valid = 1'b1; W = 8'sd20; X = 8'sd20;
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || Out !== 8'sd0) begin
            errors++;
            $display("FAIL async_reset: got ready=%b busy=%b valid=%b out=%0d expected all 0",
                     in_ready, busy, out_valid, Out);
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_quiet: got valid=%b busy=%b expected 0 0", out_valid, busy);
            end
        end
        run_eval("after_reset", 1, 0, '{1, 1, 1, 1}, '{1, 1, 1, 1}, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_eval("start_in_acc", 7, 2, '{-9, 12, 30, -2}, '{5, 3, -1, 8}, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        vec_t wa, xa, wb, xb;
        logic signed [7:0] e;
        wa = '{11, -7, 3, 25}; xa = '{4, 6, -9, 2};
        wb = '{-50, 40, -3, 1}; xb = '{3, 2, 7, -1};
        @(negedge clk);
        start_eval(-20, 2, wa, xa);
        feed_pairs(wa, xa, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first_valid: got %b expected 1", out_valid);
        end
        e = exp_q.pop_front();
        checks++;
        if (Out !== e) begin
            errors++;
            $display("FAIL b2b_first_out: got %0d expected %0d", Out, e);
        end
        start_eval(5, 3, wb, xb);
        feed_pairs(wb, xb, 1'b0, 1'b0);
        collect("b2b_second", 1'b1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            vec_t w, x;
            for (int i = 0; i < N_IN; i++) begin
                w[i] = int'($urandom_range(0, 255)) - 128;
                x[i] = int'($urandom_range(0, 255)) - 128;
            end
            run_eval("random", int'($urandom_range(0, 255)) - 128,
                     int'($urandom_range(0, 3)), w, x, k[0], 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_relu();
        test_linear();
        test_sign_gaps();
        test_async_reset();
        test_start_ignored();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
# neuron_mac_seq

Sequential N-input neuron with bias, a registered activation stage and valid/ready input handshake. Generalises the single-pair neuron_Nbits: one weighted-input pair per cycle is accumulated over N_IN inputs into a wide, overflow-free accumulator. A selectable activation (step, saturated ReLU, saturated linear, sign) then produces one WIDTH-bit result per start. It sits between the input-vector sequencer and the layer output register bank.

## Interface
- WIDTH, 8, signed width of W, X, bias and Out
- N_IN, 4, number of (W, X) pairs accumulated per result; N_IN ≥ 1
- ACC_WIDTH, 2*WIDTH+$clog2(N_IN)+1, signed accumulator width (derived; not overridden)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin a new neuron evaluation; honoured only in IDLE
- bias  in  WIDTH  signed bias, sampled with start
- mode  in  2  activation select, sampled with start: 0 step, 1 ReLU-sat, 2 linear-sat, 3 sign
- in_valid  in  1  W/X pair present
- in_ready  out  1  block accepts a pair this cycle
- W  in  WIDTH  signed weight
- X  in  WIDTH  signed input
- busy  out  1  high whenever state ≠ IDLE
- out_valid  out  1  one-cycle pulse: Out holds a new result
- Out  out  WIDTH  signed activation result; held until the next result

## Operation
- FSM states: IDLE, ACC, ACT.
  - IDLE: in_ready=0. On start: acc ← sign-extended bias, mode_r ← mode, cnt ← 0, go to ACC.
  - ACC: in_ready=1. On each edge with in_valid=1: acc ← acc + W*X (full signed product, sign-extended), cnt ← cnt+1. When the accepted pair is pair N_IN (cnt=N_IN-1), go to ACT. With in_valid=0: hold.
  - ACT: in_ready=0. Register Out ← f(acc), assert out_valid for one cycle, go to IDLE.
- Activation f (limits: MAX=2^(WIDTH-1)-1, MIN=-2^(WIDTH-1)):
  - Mode 0 (step): 1 if acc>0, else 0.
  - Mode 1 (ReLU-sat): 0 if acc≤0, MAX if acc>MAX, else acc.
  - Mode 2 (linear-sat): clamp acc to [MIN, MAX].
  - Mode 3 (sign): +1, 0 or -1 by sign of acc.
- ACC_WIDTH guarantees no accumulator overflow for any inputs; saturation happens only in ACT.
- start outside IDLE is ignored; in_valid outside ACC is ignored.
- Changes to bias and mode after start have no effect on the running evaluation.

## Timing
- Reset (asynchronous, immediate, any state): state=IDLE, acc=0, cnt=0, mode_r=0, Out=0, out_valid=0, in_ready=0, busy=0.
- start sampled at edge s → in_ready=1 from s until the edge accepting the last pair.
- Last pair accepted at edge k → Out/out_valid update at edge k+1; out_valid low again after edge k+2; busy low after edge k+1.
- Minimum evaluation (in_valid held high): start edge s, pairs accepted at s+1..s+N_IN, out_valid high between edges s+N_IN+1 and s+N_IN+2.
- start may be asserted in the out_valid cycle; it is accepted at the next edge (state is IDLE).
- in_valid gaps stretch ACC only; the result is unchanged.
- Reset mid-ACC discards the partial sum; no out_valid is produced.

## Test plan
- Step, bias 0, pairs (-3,2),(5,-4),(1,1),(2,2), in_valid continuous → acc=-21, Out=0, out_valid exactly 1 cycle, N_IN+1 edges after start.
- ReLU-sat, bias 10, four pairs (64,2) → acc=522, Out=127; repeat with bias -128, pairs (1,1)x4 → Out=0.
- Linear-sat, bias -5, four pairs (-128,127) → acc=-65029, Out=-128; bias 3, pairs (2,3),(−1,4),(0,9),(1,1) → Out=6.
- Sign mode, bias 0, pairs (1,-1),(0,0),(0,0),(0,0) → Out=-1. Same pairs with random in_valid gaps → same Out; in_ready=0 outside ACC.
- rst pulsed low asynchronously (mid-cycle) after 2 of 4 pairs accepted → all outputs 0 immediately, busy=0; a new start with bias 1, pairs (1,1)x4, step mode → Out=1.
- start pulsed during ACC with a different bias/mode → ignored, result unchanged. start asserted in the out_valid cycle → new evaluation begins next edge.
